// File: rtl/add_pkg.sv
// Shared definitions for the add_sched block: default data width, FSM state
// encodings and requester index constants.
package add_pkg;

  localparam int DW_DEF = 32;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage : add_pkg

// File: rtl/add_sched_if.sv
// Handshake bundle between two requesters, the consumer and add_sched.
// Optional macro ADD_SCHED_CARRY_EN adds the registered carry-out resp_cout.
interface add_sched_if
  import add_pkg::*;
#(
  parameter int DW = DW_DEF
);

  logic          req0_valid;
  logic [DW-1:0] req0_a;
  logic [DW-1:0] req0_b;
  logic          req0_ready;

  logic          req1_valid;
  logic [DW-1:0] req1_a;
  logic [DW-1:0] req1_b;
  logic          req1_ready;

  logic          resp_valid;
  logic          resp_ready;
  logic          resp_id;
  logic [DW-1:0] resp_sum;
`ifdef ADD_SCHED_CARRY_EN
  logic          resp_cout;
`endif

  // Requesters and consumer side.
  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  resp_valid, resp_id, resp_sum,
`ifdef ADD_SCHED_CARRY_EN
    input  resp_cout,
`endif
    output resp_ready
  );

  // Scheduler side.
  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output resp_valid, resp_id, resp_sum,
`ifdef ADD_SCHED_CARRY_EN
    output resp_cout,
`endif
    input  resp_ready
  );

endinterface : add_sched_if

// File: rtl/add_sched_rr_arb2.sv
// Two-way round-robin grant. A lone valid wins outright; on a tie, or with
// nothing valid, the grant points at the requester that was not served last.
module rr_arb2
  import add_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last,
  output logic       grant
);

  // Pick the granted requester from the valids and the last-served index.
  always_comb begin
    grant = ~last;
    case (valid)
      2'b01:   grant = REQ0;
      2'b10:   grant = REQ1;
      default: grant = ~last;
    endcase
  end

endmodule : rr_arb2

// File: rtl/add_sched.sv
// add_sched: two requesters share one adder through a round-robin grant and a
// single-entry result register. Results appear one cycle after acceptance and
// can stream back-to-back while the consumer keeps resp_ready high.
// Optional macro ADD_SCHED_CARRY_EN adds resp_cout (bit DW of a+b).
module add_sched
  import add_pkg::*;
#(
  parameter int   DW    = DW_DEF,
  parameter logic LAST0 = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  add_sched_if.slave  bus
);

  state_t        state_r;
  state_t        state_nxt_s;
  logic          last_r;
  logic          grant_s;
  logic          can_accept_s;
  logic          accept_s;
  logic [DW-1:0] sel_a_s;
  logic [DW-1:0] sel_b_s;
  logic [DW:0]   sum_s;
  logic          resp_id_r;
  logic [DW-1:0] resp_sum_r;
  logic          resp_cout_r;

  rr_arb2 u_arb (
    .valid ({bus.req1_valid, bus.req0_valid}),
    .last  (last_r),
    .grant (grant_s)
  );

  // Handshake decode: room for a new result, per-requester readys, accept.
  always_comb begin
    can_accept_s   = ~rst & ((state_r == IDLE) | bus.resp_ready);
    bus.req0_ready = can_accept_s & (grant_s == REQ0);
    bus.req1_ready = can_accept_s & (grant_s == REQ1);
    accept_s       = (bus.req0_valid & bus.req0_ready) |
                     (bus.req1_valid & bus.req1_ready);
  end

  // Operand mux in front of the shared adder; the extra bit captures carry.
  always_comb begin
    if (grant_s == REQ1) begin
      sel_a_s = bus.req1_a;
      sel_b_s = bus.req1_b;
    end else begin
      sel_a_s = bus.req0_a;
      sel_b_s = bus.req0_b;
    end
    sum_s = {1'b0, sel_a_s} + {1'b0, sel_b_s};
  end

  // FSM next state: an accept always fills; a drained result empties.
  always_comb begin
    state_nxt_s = state_r;
    if (accept_s) begin
      state_nxt_s = FULL;
    end else if ((state_r == FULL) && bus.resp_ready) begin
      state_nxt_s = IDLE;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Round-robin pointer moves only when a request is actually taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= LAST0;
    end else if (accept_s) begin
      last_r <= grant_s;
    end else begin
      last_r <= last_r;
    end
  end

  // Result register: loaded on accept, otherwise held stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_id_r   <= 1'b0;
      resp_sum_r  <= '0;
      resp_cout_r <= 1'b0;
    end else if (accept_s) begin
      resp_id_r   <= grant_s;
      resp_sum_r  <= sum_s[DW-1:0];
      resp_cout_r <= sum_s[DW];
    end else begin
      resp_id_r   <= resp_id_r;
      resp_sum_r  <= resp_sum_r;
      resp_cout_r <= resp_cout_r;
    end
  end

  assign bus.resp_valid = (state_r == FULL);
  assign bus.resp_id    = resp_id_r;
  assign bus.resp_sum   = resp_sum_r;

`ifdef ADD_SCHED_CARRY_EN
  assign bus.resp_cout  = resp_cout_r;
`else
  // Carry is computed but intentionally discarded in this build.
  logic unused_cout_s;
  assign unused_cout_s  = resp_cout_r;
`endif

endmodule : add_sched

// File: tb/tb_add_sched.sv
// Directed self-checking bench for add_sched.
module tb_add_sched;
  import add_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  add_sched_if #(.DW(32)) bus ();

  add_sched #(.DW(32), .LAST0(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req0_a     = 32'h0;
    bus.req0_b     = 32'h0;
    bus.req1_valid = 1'b0;
    bus.req1_a     = 32'h0;
    bus.req1_b     = 32'h0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle_inputs();
    bus.resp_ready = 1'b1;
    rst = 1'b1;

    // Reset with a valid request present: must not be accepted.
    bus.req0_valid = 1'b1;
    bus.req0_a     = 32'h1;
    bus.req0_b     = 32'h1;
    @(negedge clk);
    check_val("rst_ready0", {63'd0, bus.req0_ready}, 64'd0);
    check_val("rst_ready1", {63'd0, bus.req1_ready}, 64'd0);
    @(negedge clk);
    check_val("rst_valid", {63'd0, bus.resp_valid}, 64'd0);
    check_val("rst_id",    {63'd0, bus.resp_id},    64'd0);
    check_val("rst_sum",   {32'd0, bus.resp_sum},   64'd0);

    // Single request from requester 0.
    rst = 1'b0;
    bus.req0_a = 32'h0000_0005;
    bus.req0_b = 32'h0000_0007;
    #1;
    check_val("r0_ready0", {63'd0, bus.req0_ready}, 64'd1);
    check_val("r0_ready1", {63'd0, bus.req1_ready}, 64'd0);
    @(negedge clk);
    check_val("r0_valid", {63'd0, bus.resp_valid}, 64'd1);
    check_val("r0_id",    {63'd0, bus.resp_id},    64'd0);
    check_val("r0_sum",   {32'd0, bus.resp_sum},   64'h0000_000C);
    idle_inputs();
    @(negedge clk);
    check_val("drain_valid", {63'd0, bus.resp_valid}, 64'd0);

    // Requester 1 with wraparound.
    bus.req1_valid = 1'b1;
    bus.req1_a     = 32'hFFFF_FFFF;
    bus.req1_b     = 32'h0000_0002;
    #1;
    check_val("r1_ready1", {63'd0, bus.req1_ready}, 64'd1);
    @(negedge clk);
    idle_inputs();
    check_val("wrap_id",  {63'd0, bus.resp_id},  64'd1);
    check_val("wrap_sum", {32'd0, bus.resp_sum}, 64'h0000_0001);
`ifdef ADD_SCHED_CARRY_EN
    check_val("wrap_cout", {63'd0, bus.resp_cout}, 64'd1);
`endif
    // A request dropped before acceptance changes nothing.
    bus.resp_ready = 1'b0;
    @(negedge clk);
    bus.req0_valid = 1'b1;
    bus.req0_a     = 32'h55;
    #1;
    check_val("drop_ready0", {63'd0, bus.req0_ready}, 64'd0);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    check_val("drop_sum", {32'd0, bus.resp_sum}, 64'h0000_0001);
    bus.resp_ready = 1'b1;

    // Fresh reset, then both requesters valid every cycle: ids alternate.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_b     = 32'h1;
    bus.req1_b     = 32'h2;
    for (int i = 0; i < 4; i++) begin
      bus.req0_a = 32'h10 + 32'(i);
      bus.req1_a = 32'h100 + 32'(i);
      @(negedge clk);
      check_val($sformatf("rr_id%0d", i), {63'd0, bus.resp_id}, 64'(i % 2));
      check_val($sformatf("rr_sum%0d", i), {32'd0, bus.resp_sum},
                (i % 2 == 0) ? 64'(32'h11 + 32'(i)) : 64'(32'h102 + 32'(i)));
      check_val($sformatf("rr_valid%0d", i), {63'd0, bus.resp_valid}, 64'd1);
    end

    // Stall for 4 cycles: result held, no requester ready.
    bus.req0_a     = 32'h14;
    bus.req1_a     = 32'h104;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val($sformatf("stall_rdy0_%0d", i), {63'd0, bus.req0_ready}, 64'd0);
      check_val($sformatf("stall_rdy1_%0d", i), {63'd0, bus.req1_ready}, 64'd0);
      check_val($sformatf("stall_id_%0d", i),   {63'd0, bus.resp_id},    64'd1);
      check_val($sformatf("stall_sum_%0d", i),  {32'd0, bus.resp_sum},   64'h105);
      check_val($sformatf("stall_vld_%0d", i),  {63'd0, bus.resp_valid}, 64'd1);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    #1;
    check_val("unstall_rdy0", {63'd0, bus.req0_ready}, 64'd1);
    @(negedge clk);
    idle_inputs();
    check_val("unstall_id",  {63'd0, bus.resp_id},  64'd0);
    check_val("unstall_sum", {32'd0, bus.resp_sum}, 64'h15);

    // Reset while holding a stalled result (last served was requester 0).
    bus.resp_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_val("rst2_valid", {63'd0, bus.resp_valid}, 64'd0);
    check_val("rst2_sum",   {32'd0, bus.resp_sum},   64'd0);
    rst = 1'b0;
    bus.resp_ready = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_a     = 32'h1;
    bus.req0_b     = 32'h1;
    bus.req1_valid = 1'b1;
    bus.req1_a     = 32'h2;
    bus.req1_b     = 32'h2;
    #1;
    check_val("rst2_tie_rdy0", {63'd0, bus.req0_ready}, 64'd1);
    check_val("rst2_tie_rdy1", {63'd0, bus.req1_ready}, 64'd0);
    @(negedge clk);
    idle_inputs();
    check_val("rst2_tie_id",  {63'd0, bus.resp_id},  64'd0);
    check_val("rst2_tie_sum", {32'd0, bus.resp_sum}, 64'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_add_sched
